// File: rtl/snac_pad_pkg.sv
// Shared types and constants for the SNAC Mega Drive pad reader.
// Button bit positions follow the BTN vector {MODE,X,Y,Z,START,C,B,A,RIGHT,LEFT,DOWN,UP}.
package snac_pad_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PHASE,
    S_GUARD
  } state_t;

  localparam int unsigned BTN_W     = 12;
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;
  localparam int unsigned BTN_C     = 6;
  localparam int unsigned BTN_START = 7;
  localparam int unsigned BTN_Z     = 8;
  localparam int unsigned BTN_Y     = 9;
  localparam int unsigned BTN_X     = 10;
  localparam int unsigned BTN_MODE  = 11;

  localparam int unsigned PH_DPAD = 0;
  localparam int unsigned PH_PRES = 1;
  localparam int unsigned PH_SIX  = 5;
  localparam int unsigned PH_XYZ  = 6;
  localparam int unsigned PH_LAST = 7;

  // Extra buttons only count on a 6-button pad; nothing counts without a pad.
  function automatic logic [BTN_W-1:0] btn_decode(input logic [BTN_W-1:0] raw,
                                                  input logic             pres,
                                                  input logic             six);
    logic [BTN_W-1:0] b;
    b = raw;
    if (!six)
      b[BTN_MODE:BTN_Z] = '0;
    if (!pres)
      b = '0;
    return b;
  endfunction

endpackage

// File: rtl/snac_sync2.sv
// Two-flop synchronizer for asynchronous pad pins.
// Resets to all-ones because the DB9 data lines idle high.
module snac_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta <= '1;
      Q    <= '1;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/snac_pad_reader.sv
// Host-side reader for a Mega Drive 3/6-button pad on the SNAC port: drives the
// 8-phase TH select sequence, detects pad type and publishes an active-high button vector.
module snac_pad_reader
  import snac_pad_pkg::*;
#(
  parameter int unsigned SETTLE = 16,
  parameter int unsigned GUARD  = 15000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CE,
  input  logic        ENABLE,
  input  logic        STROBE,
  input  logic [5:0]  PIN_IN,
  output logic        TH_OUT,
  output logic        TH_OE,
  output logic [11:0] BTN,
  output logic        PRESENT,
  output logic        SIX_BTN,
  output logic        VALID,
  output logic        BUSY
);

  localparam int unsigned CNT_MAX = (SETTLE > GUARD) ? SETTLE : GUARD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [5:0] pin_sync;
  logic [5:0] s;

  snac_sync2 #(.WIDTH(6)) u_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .D       (PIN_IN),
    .Q       (pin_sync)
  );

  assign s = ~pin_sync;

  state_t          state, state_d;
  logic [2:0]      phase, phase_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            pending, pending_d;
  logic            sample, commit;
  logic            th_level;
  logic            th_oe_q;
  logic            settle_last, guard_last;

  logic [BTN_W-1:0] sh_btn;
  logic             sh_pres, sh_six;
  logic [BTN_W-1:0] btn_q;
  logic             present_q, six_q, valid_q;

  assign settle_last = (cnt == CW'(SETTLE - 1));
  assign guard_last  = (cnt == CW'(GUARD - 1));

  always_comb begin
    state_d   = state;
    phase_d   = phase;
    cnt_d     = cnt;
    pending_d = pending;
    sample    = 1'b0;
    commit    = 1'b0;
    th_level  = 1'b1;

    unique case (state)
      S_IDLE: begin
        if (STROBE && ENABLE) begin
          state_d = S_PHASE;
          phase_d = '0;
          cnt_d   = '0;
        end
      end

      S_PHASE: begin
        th_level = ~phase[0];
        if (STROBE)
          pending_d = 1'b1;
        if (CE) begin
          if (settle_last) begin
            sample = 1'b1;
            cnt_d  = '0;
            if (phase == 3'(PH_LAST)) begin
              state_d = S_GUARD;
              commit  = 1'b1;
            end else begin
              phase_d = phase + 3'd1;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end

      S_GUARD: begin
        if (STROBE)
          pending_d = 1'b1;
        if (CE) begin
          if (guard_last) begin
            cnt_d = '0;
            // A strobe landing on the final guard tick is merged into the restart
            // rather than left pending in IDLE.
            if (pending || STROBE) begin
              state_d   = S_PHASE;
              phase_d   = '0;
              pending_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (!ENABLE) begin
      state_d   = S_IDLE;
      phase_d   = '0;
      cnt_d     = '0;
      pending_d = 1'b0;
      sample    = 1'b0;
      commit    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      phase   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      th_oe_q <= 1'b0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      cnt     <= cnt_d;
      pending <= pending_d;
      th_oe_q <= ENABLE;
    end
  end

  // Shadow capture: only these registers change mid-poll.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_btn  <= '0;
      sh_pres <= 1'b0;
      sh_six  <= 1'b0;
    end else if (sample) begin
      if (phase == 3'(PH_DPAD)) begin
        sh_btn[BTN_UP]    <= s[0];
        sh_btn[BTN_DOWN]  <= s[1];
        sh_btn[BTN_LEFT]  <= s[2];
        sh_btn[BTN_RIGHT] <= s[3];
        sh_btn[BTN_B]     <= s[4];
        sh_btn[BTN_C]     <= s[5];
      end
      if (phase == 3'(PH_PRES)) begin
        sh_pres          <= s[3] & s[2];
        sh_btn[BTN_A]     <= s[4];
        sh_btn[BTN_START] <= s[5];
      end
      if (phase == 3'(PH_SIX))
        sh_six <= &s[3:0];
      if (phase == 3'(PH_XYZ)) begin
        sh_btn[BTN_Z]    <= s[0];
        sh_btn[BTN_Y]    <= s[1];
        sh_btn[BTN_X]    <= s[2];
        sh_btn[BTN_MODE] <= s[3];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_q     <= '0;
      present_q <= 1'b0;
      six_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= commit;
      if (!ENABLE) begin
        btn_q     <= '0;
        present_q <= 1'b0;
        six_q     <= 1'b0;
      end else if (commit) begin
        btn_q     <= btn_decode(sh_btn, sh_pres, sh_six);
        present_q <= sh_pres;
        six_q     <= sh_pres & sh_six;
      end
    end
  end

  assign TH_OUT  = th_level;
  assign TH_OE   = th_oe_q;
  assign BTN     = btn_q;
  assign PRESENT = present_q;
  assign SIX_BTN = six_q;
  assign VALID   = valid_q;
  assign BUSY    = (state != S_IDLE);

endmodule
